rv_mc_core: RTL and testbench

RV_MC_CORE -- requirements
Module: rv_mc_core

---
 rtl/rv_mc_core.sv | 211 +++++++++++++++++++++
 tb/tb_rv_mc_core.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mc_core.sv
// Multi-cycle RV-subset core: one FSM walks each instruction through fetch, decode,
// execute, memory and write-back, with req/ack handshakes to instruction and data memory.
module rv_mc_core #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned PC_W    = 10,
  parameter int unsigned DADDR_W = 12
) (
  input  logic               clk,
  input  logic               rstn,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]    dmem_wdata,
  input  logic               dmem_ack,
  input  logic [XLEN-1:0]    dmem_rdata,
  output logic [PC_W-1:0]    pc_o,
  output logic               retire,
  output logic               halt
);

  localparam int unsigned AlignW = (XLEN == 64) ? 3 : 2;
  localparam logic [2:0]  LsF3   = (XLEN == 64) ? 3'b011 : 3'b010;
  localparam logic [6:0]  OpR    = 7'b0110011;
  localparam logic [6:0]  OpI    = 7'b0010011;
  localparam logic [6:0]  OpLd   = 7'b0000011;
  localparam logic [6:0]  OpSt   = 7'b0100011;
  localparam logic [6:0]  OpBr   = 7'b1100011;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

  state_e            state_q, state_d;
  logic              run_q;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, imm_q, imm_d, alu_q, alu_d, mdr_q, mdr_d;
  logic [XLEN-1:0]   rf_q [32];
  logic              rf_we;
  logic [XLEN-1:0]   rf_wdata;

  logic [6:0] opcode, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign f7     = ir_q[31:25];

  logic is_r, is_i, is_ld, is_st, is_br, legal;
  assign is_r  = (opcode == OpR);
  assign is_i  = (opcode == OpI);
  assign is_ld = (opcode == OpLd);
  assign is_st = (opcode == OpSt);
  assign is_br = (opcode == OpBr);

  always_comb begin
    legal = 1'b0;
    if (is_r) begin
      legal = ((f7 == 7'b0000000) &&
               (f3 == 3'b000 || f3 == 3'b100 || f3 == 3'b110 || f3 == 3'b111)) ||
              ((f7 == 7'b0100000) && (f3 == 3'b000));
    end else if (is_i) begin
      legal = (f3 == 3'b000 || f3 == 3'b110 || f3 == 3'b111);
    end else if (is_ld || is_st) begin
      legal = (f3 == LsF3);
    end else if (is_br) begin
      legal = (f3 == 3'b000 || f3 == 3'b001);
    end
  end

  logic [XLEN-1:0] imm_dec;
  always_comb begin
    if (is_st) begin
      imm_dec = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    end else if (is_br) begin
      imm_dec = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    end else begin
      imm_dec = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
    end
  end

  logic [XLEN-1:0] op_b, alu_res;
  logic            taken, misaligned;
  always_comb begin
    op_b    = is_r ? b_q : imm_q;
    alu_res = a_q + op_b;
    if (is_r || is_i) begin
      case (f3)
        3'b100:  alu_res = a_q ^ op_b;
        3'b110:  alu_res = a_q | op_b;
        3'b111:  alu_res = a_q & op_b;
        default: alu_res = (is_r && f7[5]) ? a_q - op_b : a_q + op_b;
      endcase
    end
  end
  // funct3[0] distinguishes bne from beq
  assign taken      = (a_q == b_q) ^ f3[0];
  assign misaligned = (alu_res[AlignW-1:0] != '0);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    imm_d    = imm_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    rf_we    = 1'b0;
    rf_wdata = alu_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    retire   = 1'b0;
    unique case (state_q)
      StFetch: begin
        imem_req = run_q;
        if (run_q && imem_ack) begin
          ir_d    = imem_rdata;
          state_d = StDecode;
        end
      end
      StDecode: begin
        a_d     = rf_q[rs1];
        b_d     = rf_q[rs2];
        imm_d   = imm_dec;
        state_d = legal ? StExec : StHalt;
      end
      StExec: begin
        alu_d = alu_res;
        if (is_br) begin
          retire  = 1'b1;
          pc_d    = taken ? pc_q + imm_q[PC_W+1:2] : pc_q + 1'b1;
          state_d = StFetch;
        end else if (is_ld || is_st) begin
          state_d = misaligned ? StHalt : StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          if (is_st) begin
            pc_d    = pc_q + 1'b1;
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            mdr_d   = dmem_rdata;
            state_d = StWb;
          end
        end
      end
      StWb: begin
        rf_we    = (rd != 5'd0);
        rf_wdata = is_ld ? mdr_q : alu_q;
        pc_d     = pc_q + 1'b1;
        retire   = 1'b1;
        state_d  = StFetch;
      end
      StHalt: begin
      end
      default: state_d = StHalt;
    endcase
  end

  // run_q holds off the first fetch request until the first edge after reset release
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StFetch;
      run_q   <= 1'b0;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rd] <= rf_wdata;
    end
  end

  assign imem_addr  = pc_q;
  assign pc_o       = pc_q;
  assign dmem_we    = is_st;
  assign dmem_addr  = alu_q[DADDR_W-1:0];
  assign dmem_wdata = b_q;
  assign halt       = (state_q == StHalt);

endmodule

// File: tb/tb_rv_mc_core.sv
// Directed bench for rv_mc_core: zero-wait instruction memory, data memory with
// programmable ack delay or manual ack, and a negedge monitor logging retires and data accesses.
module tb_rv_mc_core;
  localparam int XLEN = 64, PC_W = 10, DADDR_W = 12;

  logic               clk, rstn;
  logic               imem_req, imem_ack;
  logic [PC_W-1:0]    imem_addr;
  logic [31:0]        imem_rdata;
  logic               dmem_req, dmem_we, dmem_ack;
  logic [DADDR_W-1:0] dmem_addr;
  logic [XLEN-1:0]    dmem_wdata, dmem_rdata;
  logic [PC_W-1:0]    pc_o;
  logic               retire, halt;

  rv_mc_core #(.XLEN(XLEN), .PC_W(PC_W), .DADDR_W(DADDR_W)) dut (
    .clk(clk), .rstn(rstn),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc_o(pc_o), .retire(retire), .halt(halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;

  logic [31:0] imem [1024];
  logic [63:0] dmem [512];
  int dwait = 0, dcnt = 0;
  logic man_mode = 1'b0, man_ack = 1'b0;

  assign imem_ack   = imem_req;
  assign imem_rdata = imem[imem_addr];
  assign dmem_ack   = man_mode ? man_ack : (dmem_req && dcnt == dwait);
  assign dmem_rdata = dmem[dmem_addr[DADDR_W-1:3]];

  always @(posedge clk) begin
    if (dmem_req && !dmem_ack) dcnt <= dcnt + 1;
    else dcnt <= 0;
    if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr[DADDR_W-1:3]] <= dmem_wdata;
  end

  int retire_q[$];
  int pcs_q[$];
  logic [DADDR_W-1:0] t_addr[$];
  logic t_we[$];
  logic [63:0] t_wdata[$];
  int t_len[$];
  int cyc = 0, dlen = 0;
  bit prev_ret = 0, saw_dreq = 0, saw_ireq = 0;

  always @(negedge clk) begin
    cyc++;
    if (prev_ret) pcs_q.push_back(int'(pc_o));
    prev_ret = retire;
    if (retire) retire_q.push_back(cyc);
    if (imem_req) saw_ireq = 1;
    if (dmem_req) begin
      saw_dreq = 1;
      dlen++;
      if (dmem_ack) begin
        t_addr.push_back(dmem_addr);
        t_we.push_back(dmem_we);
        t_wdata.push_back(dmem_wdata);
        t_len.push_back(dlen);
        dlen = 0;
      end
    end else begin
      dlen = 0;
    end
  end

  localparam logic [31:0] Halt7F = 32'h0000007F;

  function automatic logic [31:0] enc_i(int rd, int rs1, int imm, logic [2:0] f3,
                                        logic [6:0] op);
    logic [11:0] im;
    logic [4:0] d, s;
    im = imm[11:0]; d = rd[4:0]; s = rs1[4:0];
    return {im, s, f3, d, op};
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, int rs2, int rs1, logic [2:0] f3, int rd);
    logic [4:0] d, s1, s2;
    d = rd[4:0]; s1 = rs1[4:0]; s2 = rs2[4:0];
    return {f7, s2, s1, f3, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(int rs2, int rs1, int imm);
    logic [11:0] im;
    logic [4:0] s1, s2;
    im = imm[11:0]; s1 = rs1[4:0]; s2 = rs2[4:0];
    return {im[11:5], s2, s1, 3'b011, im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(logic [2:0] f3, int rs1, int rs2, int imm);
    logic [12:0] im;
    logic [4:0] s1, s2;
    im = imm[12:0]; s1 = rs1[4:0]; s2 = rs2[4:0];
    return {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'b1100011};
  endfunction

  task automatic fill_imem(logic [31:0] val);
    for (int i = 0; i < 1024; i++) imem[i] = val;
  endtask

  task automatic clear_mon();
    retire_q.delete(); pcs_q.delete();
    t_addr.delete(); t_we.delete(); t_wdata.delete(); t_len.delete();
    cyc = 0; saw_dreq = 0; saw_ireq = 0; prev_ret = 0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    clear_mon();
    rstn = 1'b1;
  endtask

  task automatic run_until_halt(int maxc);
    int n;
    n = 0;
    while (!halt && n < maxc) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (halt !== 1'b1) begin
      bad++; $display("FAIL halt_timeout got halt=%0b want 1 after %0d cycles", halt, maxc);
    end
  endtask

  task automatic wait_pc(logic [PC_W-1:0] target, int maxc, string nm);
    int n;
    n = 0;
    while (pc_o !== target && n < maxc) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (pc_o !== target) begin
      bad++; $display("FAIL %s got pc=%0d want %0d", nm, pc_o, target);
    end
  endtask

  task automatic load_arith_prog();
    fill_imem(Halt7F);
    imem[0] = enc_i(1, 0, 5, 3'b000, 7'b0010011);
    imem[1] = enc_i(2, 0, -3, 3'b000, 7'b0010011);
    imem[2] = enc_r(7'b0000000, 2, 1, 3'b000, 3);
    imem[3] = enc_s(3, 0, 8);
    imem[4] = enc_i(4, 0, 8, 3'b011, 7'b0000011);
    imem[5] = enc_s(4, 0, 16);
  endtask

  task automatic test_reset();
    fill_imem(enc_i(0, 0, 0, 3'b000, 7'b0010011));
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (pc_o !== 0) begin bad++; $display("FAIL rst_pc got %0d want 0", pc_o); end
    total++; if (imem_req !== 0) begin bad++; $display("FAIL rst_ireq got %0b want 0", imem_req); end
    total++; if (dmem_req !== 0) begin bad++; $display("FAIL rst_dreq got %0b want 0", dmem_req); end
    total++; if (retire !== 0) begin bad++; $display("FAIL rst_retire got %0b want 0", retire); end
    total++; if (halt !== 0) begin bad++; $display("FAIL rst_halt got %0b want 0", halt); end
    rstn = 1'b1;
    #1;
    total++;
    if (imem_req !== 0) begin bad++; $display("FAIL ireq_pre_edge got %0b want 0", imem_req); end
    @(posedge clk); #1;
    total++;
    if (imem_req !== 1) begin bad++; $display("FAIL ireq_first_edge got %0b want 1", imem_req); end
    total++;
    if (imem_addr !== 0) begin bad++; $display("FAIL iaddr_first got %0d want 0", imem_addr); end
  endtask

  task automatic test_alu_mem();
    load_arith_prog();
    dwait = 3;
    do_reset();
    run_until_halt(300);
    total++;
    if (retire_q.size() != 6) begin bad++; $display("FAIL am_retires got %0d want 6", retire_q.size()); end
    total++;
    if (retire_q[1] - retire_q[0] != 4) begin
      bad++; $display("FAIL am_gap1 got %0d want 4", retire_q[1] - retire_q[0]);
    end
    total++;
    if (retire_q[2] - retire_q[1] != 4) begin
      bad++; $display("FAIL am_gap2 got %0d want 4", retire_q[2] - retire_q[1]);
    end
    total++; if (pcs_q[2] != 3) begin bad++; $display("FAIL am_pc3 got %0d want 3", pcs_q[2]); end
    total++;
    if (t_addr.size() != 3) begin bad++; $display("FAIL am_ntxn got %0d want 3", t_addr.size()); end
    total++; if (t_addr[0] !== 8) begin bad++; $display("FAIL sd_addr got %0d want 8", t_addr[0]); end
    total++; if (t_we[0] !== 1) begin bad++; $display("FAIL sd_we got %0b want 1", t_we[0]); end
    total++; if (t_wdata[0] !== 2) begin bad++; $display("FAIL sd_x3 got %0h want 2", t_wdata[0]); end
    total++; if (t_len[0] != 4) begin bad++; $display("FAIL sd_len got %0d want 4", t_len[0]); end
    total++; if (t_addr[1] !== 8) begin bad++; $display("FAIL ld_addr got %0d want 8", t_addr[1]); end
    total++; if (t_we[1] !== 0) begin bad++; $display("FAIL ld_we got %0b want 0", t_we[1]); end
    total++; if (t_len[1] != 4) begin bad++; $display("FAIL ld_len got %0d want 4", t_len[1]); end
    total++; if (t_wdata[2] !== 2) begin bad++; $display("FAIL ld_x4 got %0h want 2", t_wdata[2]); end
    total++; if (pc_o !== 6) begin bad++; $display("FAIL am_halt_pc got %0d want 6", pc_o); end
  endtask

  task automatic test_latency();
    load_arith_prog();
    dwait = 0;
    do_reset();
    run_until_halt(200);
    total++;
    if (retire_q[3] - retire_q[2] != 4) begin
      bad++; $display("FAIL lat_store got %0d want 4", retire_q[3] - retire_q[2]);
    end
    total++;
    if (retire_q[4] - retire_q[3] != 5) begin
      bad++; $display("FAIL lat_load got %0d want 5", retire_q[4] - retire_q[3]);
    end
    total++;
    if (retire_q[5] - retire_q[4] != 4) begin
      bad++; $display("FAIL lat_store2 got %0d want 4", retire_q[5] - retire_q[4]);
    end
  endtask

  task automatic test_branch();
    fill_imem(enc_i(0, 0, 0, 3'b000, 7'b0010011));
    imem[4] = enc_b(3'b001, 0, 0, -8);
    imem[5] = enc_b(3'b000, 0, 0, -4);
    do_reset();
    wait_pc(4, 40, "br_reach4");
    @(negedge clk);
    total++; if (retire !== 0) begin bad++; $display("FAIL br_dec_retire got %0b want 0", retire); end
    @(negedge clk);
    total++; if (retire !== 1) begin bad++; $display("FAIL bne_retire got %0b want 1", retire); end
    @(negedge clk);
    total++; if (pc_o !== 5) begin bad++; $display("FAIL bne_untaken got %0d want 5", pc_o); end
    repeat (2) @(negedge clk);
    total++; if (retire !== 1) begin bad++; $display("FAIL beq_retire got %0b want 1", retire); end
    @(negedge clk);
    total++; if (pc_o !== 4) begin bad++; $display("FAIL beq_taken got %0d want 4", pc_o); end
  endtask

  task automatic test_wrap();
    fill_imem(Halt7F);
    imem[0]    = enc_b(3'b000, 0, 0, -4);
    imem[1023] = enc_i(6, 0, 9, 3'b000, 7'b0010011);
    do_reset();
    wait_pc(1023, 20, "wrap_reach");
    repeat (3) @(negedge clk);
    total++; if (pc_o !== 1023) begin bad++; $display("FAIL wrap_hold got %0d want 1023", pc_o); end
    @(negedge clk);
    total++; if (pc_o !== 0) begin bad++; $display("FAIL wrap_zero got %0d want 0", pc_o); end
  endtask

  task automatic test_x0_halt();
    fill_imem(Halt7F);
    imem[0] = enc_i(5, 0, 1, 3'b000, 7'b0010011);
    imem[1] = enc_i(0, 0, 7, 3'b000, 7'b0010011);
    imem[2] = enc_r(7'b0000000, 0, 0, 3'b000, 5);
    imem[3] = enc_s(5, 0, 0);
    dwait = 1;
    do_reset();
    run_until_halt(100);
    total++; if (t_wdata[0] !== 0) begin bad++; $display("FAIL x5_zero got %0h want 0", t_wdata[0]); end
    total++; if (pc_o !== 4) begin bad++; $display("FAIL illegal_pc got %0d want 4", pc_o); end
    clear_mon();
    repeat (20) @(negedge clk);
    total++; if (saw_ireq) begin bad++; $display("FAIL halt_ireq got 1 want 0"); end
    total++; if (saw_dreq) begin bad++; $display("FAIL halt_dreq got 1 want 0"); end
    total++;
    if (retire_q.size() != 0) begin bad++; $display("FAIL halt_retire got %0d want 0", retire_q.size()); end
    total++; if (pc_o !== 4) begin bad++; $display("FAIL halt_pc_frozen got %0d want 4", pc_o); end
    total++; if (halt !== 1) begin bad++; $display("FAIL halt_stays got %0b want 1", halt); end
  endtask

  task automatic test_misaligned();
    fill_imem(Halt7F);
    imem[0] = enc_i(7, 0, 4, 3'b011, 7'b0000011);
    do_reset();
    run_until_halt(50);
    total++; if (saw_dreq) begin bad++; $display("FAIL mis_dreq got 1 want 0"); end
    total++; if (pc_o !== 0) begin bad++; $display("FAIL mis_pc got %0d want 0", pc_o); end
    total++;
    if (retire_q.size() != 0) begin bad++; $display("FAIL mis_retire got %0d want 0", retire_q.size()); end
  endtask

  task automatic test_reset_mid_mem();
    int n;
    fill_imem(enc_i(0, 0, 0, 3'b000, 7'b0010011));
    imem[0] = enc_s(0, 0, 8);
    man_mode = 1'b1;
    man_ack  = 1'b0;
    do_reset();
    n = 0;
    while (dmem_req !== 1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++; if (dmem_req !== 1) begin bad++; $display("FAIL mid_reach got %0b want 1", dmem_req); end
    #2 rstn = 1'b0;
    #1;
    total++; if (dmem_req !== 0) begin bad++; $display("FAIL mid_dreq_drop got %0b want 0", dmem_req); end
    total++; if (imem_req !== 0) begin bad++; $display("FAIL mid_ireq got %0b want 0", imem_req); end
    @(negedge clk);
    clear_mon();
    rstn    = 1'b1;
    man_ack = 1'b1;
    @(posedge clk); #1;
    total++; if (imem_req !== 1) begin bad++; $display("FAIL mid_refetch got %0b want 1", imem_req); end
    total++; if (imem_addr !== 0) begin bad++; $display("FAIL mid_pc got %0d want 0", imem_addr); end
    total++;
    if (t_addr.size() != 0) begin bad++; $display("FAIL mid_late_ack got %0d want 0", t_addr.size()); end
    man_ack  = 1'b0;
    man_mode = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    test_reset();
    test_alu_mem();
    test_latency();
    test_branch();
    test_wrap();
    test_x0_halt();
    test_misaligned();
    test_reset_mid_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
